// File: rtl/proc_seq_pkg.sv
// rtl/proc_seq_pkg.sv - opcodes, sequencer state encoding and immediate-operand decode
package proc_seq_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SUBI = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_IMM,
        S_WAIT,
        S_HALT,
        S_ERR
`ifdef PROC_SEQ_STEP_EN
        , S_PAUSE
`endif
    } seq_state_t;

    // Instructions whose operand word follows the opcode word in program memory
    function automatic logic needs_imm(input logic [2:0] op);
        return (op == OP_MVI) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/proc_seq_wdog.sv
// rtl/proc_seq_wdog.sv - clear/enable up-counter flagging TIMEOUT cycles without Done
module proc_seq_wdog #(
    parameter int TIMEOUT = 7,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] count;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/proc_seq_ctrl.sv
// rtl/proc_seq_ctrl.sv - instruction sequencer between program ROM and the nine-bit processor
// Optional single-step mode: PROC_SEQ_STEP_EN
module proc_seq_ctrl
    import proc_seq_pkg::*;
#(
    parameter int         AW      = 5,
    parameter int         TIMEOUT = 7,
    parameter logic [2:0] HALT_OP = OP_HALT
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [8:0]    mem_data,
    output logic [8:0]    din,
    output logic          run,
    input  logic          proc_done,
    output logic          busy,
    output logic          halted,
    output logic          timeout_err,
    output logic [AW-1:0] pc,
`ifdef PROC_SEQ_STEP_EN
    input  logic          step,
`endif
    output logic [15:0]   instr_cnt
);

    seq_state_t    state;
    seq_state_t    done_next;
    logic [AW-1:0] pc_q;
    logic [8:0]    din_hold;
    logic [15:0]   cnt_q;
    logic [2:0]    op;
    logic          wdog_expired;

    assign op = mem_data[8:6];

`ifdef PROC_SEQ_STEP_EN
    assign done_next = S_PAUSE;
`else
    assign done_next = S_FETCH;
`endif

    proc_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .clear   (state != S_WAIT),
        .enable  (state == S_WAIT),
        .expired (wdog_expired)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            pc_q     <= '0;
            din_hold <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERR: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc_q  <= '0;
                        cnt_q <= '0;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    din_hold <= mem_data;
                    if (op == HALT_OP) begin
                        state <= S_HALT;
                    end else begin
                        pc_q <= pc_q + AW'(1);
                        if (cnt_q != 16'hFFFF)
                            cnt_q <= cnt_q + 16'd1;
                        state <= needs_imm(op) ? S_IMM : S_WAIT;
                    end
                end
                // mvi completes here; addi/subi keep consuming din_hold in S_WAIT
                S_IMM: begin
                    din_hold <= mem_data;
                    pc_q     <= pc_q + AW'(1);
                    state    <= proc_done ? done_next : S_WAIT;
                end
                S_WAIT: begin
                    if (proc_done)
                        state <= done_next;
                    else if (wdog_expired)
                        state <= S_ERR;
                end
`ifdef PROC_SEQ_STEP_EN
                S_PAUSE: begin
                    if (step)
                        state <= S_FETCH;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // S_LOAD prefetches the word after the opcode so an immediate is ready in S_IMM
    assign mem_addr    = (state == S_LOAD) ? pc_q + AW'(1) : pc_q;
    assign din         = (state == S_LOAD || state == S_IMM) ? mem_data : din_hold;
    assign run         = (state == S_LOAD) && (op != HALT_OP);
    assign busy        = !(state == S_IDLE || state == S_HALT || state == S_ERR);
    assign halted      = (state == S_HALT);
    assign timeout_err = (state == S_ERR);
    assign pc          = pc_q;
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// tb/tb_proc_seq_ctrl.sv - directed bench for proc_seq_ctrl with a behavioural nine-bit processor
`timescale 1ns/1ps
module tb_proc_seq_ctrl;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  mem_addr;
    logic [8:0]  mem_data;
    logic [8:0]  din;
    logic        run;
    logic        proc_done;
    logic        busy, halted, timeout_err;
    logic [4:0]  pc;
    logic [15:0] instr_cnt;
`ifdef PROC_SEQ_STEP_EN
    logic        step = 1'b0;
`endif

    logic        start2 = 1'b0;
    logic [1:0]  mem_addr2;
    logic [8:0]  mem_data2;
    logic [8:0]  din2;
    logic        run2, run2_d, proc_done2;
    logic        busy2, halted2, timeout_err2;
    logic [1:0]  pc2;
    logic [15:0] instr_cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    int run_cycles = 0;

    logic [8:0] rom  [32];
    logic [8:0] rom2 [4];

    always #5 Clock = ~Clock;

    proc_seq_ctrl #(.AW(5), .TIMEOUT(7)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .mem_addr(mem_addr),
        .mem_data(mem_data), .din(din), .run(run), .proc_done(proc_done),
        .busy(busy), .halted(halted), .timeout_err(timeout_err), .pc(pc),
`ifdef PROC_SEQ_STEP_EN
        .step(step),
`endif
        .instr_cnt(instr_cnt)
    );

    proc_seq_ctrl #(.AW(2), .TIMEOUT(7)) dut2 (
        .Clock(Clock), .Resetn(Resetn), .start(start2), .mem_addr(mem_addr2),
        .mem_data(mem_data2), .din(din2), .run(run2), .proc_done(proc_done2),
        .busy(busy2), .halted(halted2), .timeout_err(timeout_err2), .pc(pc2),
`ifdef PROC_SEQ_STEP_EN
        .step(1'b0),
`endif
        .instr_cnt(instr_cnt2)
    );

    always @(posedge Clock) begin
        mem_data  <= rom[mem_addr];
        mem_data2 <= rom2[mem_addr2];
        run2_d    <= run2;
        if (run) run_cycles++;
    end
    // dut2 only runs mv/mvi, which finish one cycle after Run
    assign proc_done2 = run2_d;

    // Behavioural processor: IR in T0, mv/mvi done in T1, ALU ops done in T3
    logic [8:0] R [8];
    logic [8:0] IR, A, G;
    logic [1:0] tstep;
    logic       no_done = 1'b0;
    logic       proc_clr = 1'b0;
    logic [2:0] p_op;
    assign p_op = IR[8:6];
    assign proc_done = !no_done && ((tstep == 2'd1 && (p_op == 3'b000 || p_op == 3'b001)) ||
                                    tstep == 2'd3);

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tstep <= 2'd0;
            IR    <= 9'd0;
        end else if (proc_clr) begin
            tstep <= 2'd0;
            IR    <= 9'd0;
        end else begin
            case (tstep)
                2'd0: if (run) begin IR <= din; tstep <= 2'd1; end
                2'd1: begin
                    if (p_op == 3'b000) begin R[IR[5:3]] <= R[IR[2:0]]; tstep <= 2'd0; end
                    else if (p_op == 3'b001) begin R[IR[5:3]] <= din; tstep <= 2'd0; end
                    else begin A <= R[IR[5:3]]; tstep <= 2'd2; end
                end
                2'd2: begin
                    case (p_op)
                        3'b010:  G <= A + R[IR[2:0]];
                        3'b011:  G <= A - R[IR[2:0]];
                        3'b100:  G <= A + din;
                        default: G <= A - din;
                    endcase
                    tstep <= 2'd3;
                end
                default: if (!no_done) begin R[IR[5:3]] <= G; tstep <= 2'd0; end
            endcase
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 32; i++) rom[i] = 9'o700;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 300 && !halted; i++) tick(1);
        n_tests++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_halt_timeout halted=%b required 1", tag, halted);
        end
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        tick(2);
        n_tests++;
        if ({mem_addr, din, run, busy, halted, timeout_err, pc, instr_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs addr=%0d din=%0d run=%b busy=%b halted=%b err=%b pc=%0d cnt=%0d required all 0",
                     mem_addr, din, run, busy, halted, timeout_err, pc, instr_cnt);
        end
        Resetn = 1'b1;
        tick(1);
    endtask

    task automatic test_mvi_mv;
        clear_rom();
        rom[0] = 9'o100; rom[1] = 9'd5; rom[2] = 9'o010; rom[3] = 9'o700;
        pulse_start();
        wait_halt("t1");
        n_tests++;
        if (R[1] !== 9'd5) begin n_fail++; $display("FAIL t1_r1 got %0d required 5", R[1]); end
        n_tests++;
        if (pc !== 5'd3) begin n_fail++; $display("FAIL t1_pc got %0d required 3", pc); end
        n_tests++;
        if (instr_cnt !== 16'd2) begin n_fail++; $display("FAIL t1_cnt got %0d required 2", instr_cnt); end
        n_tests++;
        if ({busy, run} !== 2'b00) begin n_fail++; $display("FAIL t1_idle busy=%b run=%b required 0 0", busy, run); end
        pulse_start();
        n_tests++;
        if ({pc, busy, halted} !== {5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL t1_restart pc=%0d busy=%b halted=%b required 0 1 0", pc, busy, halted);
        end
        wait_halt("t1b");
    endtask

    task automatic test_imm_alu;
        clear_rom();
        rom[0] = 9'o120; rom[1] = 9'd3; rom[2] = 9'o420; rom[3] = 9'd4;
        rom[4] = 9'o520; rom[5] = 9'd2; rom[6] = 9'o700;
        run_cycles = 0;
        pulse_start();
        wait_halt("t2");
        n_tests++;
        if (R[2] !== 9'd5) begin n_fail++; $display("FAIL t2_r2 got %0d required 5", R[2]); end
        n_tests++;
        if (run_cycles != 3) begin n_fail++; $display("FAIL t2_run_cycles got %0d required 3", run_cycles); end
        n_tests++;
        if ({pc, instr_cnt} !== {5'd6, 16'd3}) begin
            n_fail++;
            $display("FAIL t2_pc_cnt pc=%0d cnt=%0d required 6 3", pc, instr_cnt);
        end
    endtask

    task automatic test_timeout;
        clear_rom();
        rom[0] = 9'o201;
        no_done = 1'b1;
        pulse_start();
        tick(9);
        n_tests++;
        if ({timeout_err, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL t3_before_expiry err=%b busy=%b required 0 1", timeout_err, busy);
        end
        tick(1);
        n_tests++;
        if ({timeout_err, busy, run, halted} !== 4'b1000) begin
            n_fail++;
            $display("FAIL t3_expired err=%b busy=%b run=%b halted=%b required 1 0 0 0",
                     timeout_err, busy, run, halted);
        end
        tick(4);
        n_tests++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL t3_sticky err=%b required 1", timeout_err); end
        no_done = 1'b0;
        proc_clr = 1'b1;
        tick(1);
        proc_clr = 1'b0;
        rom[0] = 9'o100; rom[1] = 9'd5; rom[2] = 9'o010; rom[3] = 9'o700;
        pulse_start();
        n_tests++;
        if ({timeout_err, busy, pc} !== {1'b0, 1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL t3_restart err=%b busy=%b pc=%0d required 0 1 0", timeout_err, busy, pc);
        end
        wait_halt("t3");
    endtask

    task automatic test_pc_wrap;
        rom2[0] = 9'o053; rom2[1] = 9'o012; rom2[2] = 9'o021; rom2[3] = 9'o170;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(9);
        tick(1);
        n_tests++;
        if ({run2, mem_addr2, pc2} !== {1'b1, 2'd0, 2'd3}) begin
            n_fail++;
            $display("FAIL t4_load run=%b addr=%0d pc=%0d required 1 0 3", run2, mem_addr2, pc2);
        end
        tick(1);
        n_tests++;
        if (din2 !== 9'o053) begin n_fail++; $display("FAIL t4_imm_din got %o required 053", din2); end
        tick(1);
        n_tests++;
        if ({pc2, instr_cnt2} !== {2'd1, 16'd4}) begin
            n_fail++;
            $display("FAIL t4_pc_after pc=%0d cnt=%0d required 1 4", pc2, instr_cnt2);
        end
    endtask

    task automatic test_reset_mid;
        clear_rom();
        rom[0] = 9'o100; rom[1] = 9'd2; rom[2] = 9'o110; rom[3] = 9'd3;
        rom[4] = 9'o201; rom[5] = 9'o700;
        pulse_start();
        tick(9);
        n_tests++;
        if ({busy, pc, instr_cnt} !== {1'b1, 5'd5, 16'd3}) begin
            n_fail++;
            $display("FAIL t5_pre busy=%b pc=%0d cnt=%0d required 1 5 3", busy, pc, instr_cnt);
        end
        Resetn = 1'b0;
        #1;
        n_tests++;
        if ({mem_addr, din, run, busy, halted, timeout_err, pc, instr_cnt} !== '0) begin
            n_fail++;
            $display("FAIL t5_async_reset addr=%0d din=%0d run=%b busy=%b pc=%0d cnt=%0d required all 0",
                     mem_addr, din, run, busy, pc, instr_cnt);
        end
        tick(1);
        Resetn = 1'b1;
        tick(1);
        pulse_start();
        wait_halt("t5");
        n_tests++;
        if ({R[0], instr_cnt} !== {9'd5, 16'd3}) begin
            n_fail++;
            $display("FAIL t5_rerun r0=%0d cnt=%0d required 5 3", R[0], instr_cnt);
        end
    endtask

`ifdef PROC_SEQ_STEP_EN
    task automatic test_step;
        clear_rom();
        rom[0] = 9'o010; rom[1] = 9'o020; rom[2] = 9'o030; rom[3] = 9'o700;
        pulse_start();
        tick(20);
        n_tests++;
        if ({instr_cnt, busy, run, halted} !== {16'd1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL t6_paused cnt=%0d busy=%b run=%b halted=%b required 1 1 0 0",
                     instr_cnt, busy, run, halted);
        end
        pulse_start();
        tick(5);
        n_tests++;
        if ({instr_cnt, pc} !== {16'd1, 5'd1}) begin
            n_fail++;
            $display("FAIL t6_start_ignored cnt=%0d pc=%0d required 1 1", instr_cnt, pc);
        end
        for (int k = 2; k <= 3; k++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            tick(15);
            n_tests++;
            if ({instr_cnt, busy} !== {16'(k), 1'b1}) begin
                n_fail++;
                $display("FAIL t6_step cnt=%0d busy=%b required %0d 1", instr_cnt, busy, k);
            end
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        wait_halt("t6");
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) R[i] = 9'd0;
        clear_rom();
        test_reset();
`ifdef PROC_SEQ_STEP_EN
        test_step();
`else
        test_mvi_mv();
        test_imm_alu();
        test_timeout();
        test_pc_wrap();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
